// File: rtl/alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// alu_wide_sequencer
//
// Purpose:
//   Multi-cycle operand sequencer placed directly upstream of an 8-bit ALU.
//   A wide (NBYTES x 8-bit) operation is accepted over a valid/ready command
//   interface. The sequencer then feeds the ALU one byte per cycle, least
//   significant byte first. Arithmetic operations chain the carry from one
//   byte to the next. The result bytes and the final flags are collected and
//   presented over a valid/ready result interface.
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   cmd_valid  in   1          command present
//   cmd_ready  out  1          sequencer can accept a command (idle)
//   cmd_a      in   8*NBYTES   operand A
//   cmd_b      in   8*NBYTES   operand B
//   cmd_s      in   3          ALU select; bit2=0 arithmetic, bit2=1 logic
//   cmd_cin    in   1          carry-in (arithmetic) / sub-select (logic)
//   alu_a      out  8          ALU operand A slice
//   alu_b      out  8          ALU operand B slice
//   alu_cin    out  1          ALU carry-in
//   alu_s      out  3          ALU select
//   alu_data   in   8          ALU result (combinational)
//   alu_cout   in   1          ALU carry-out
//   alu_ovf    in   1          ALU overflow
//   res_valid  out  1          result present
//   res_ready  in   1          consumer accepts result
//   res_data   out  8*NBYTES   wide result
//   res_cout   out  1          final carry-out
//   res_ovf    out  1          final overflow
//   res_zero   out  1          res_data == 0
// -----------------------------------------------------------------------------
module alu_wide_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8*NBYTES-1:0]   cmd_a,
  input  logic [8*NBYTES-1:0]   cmd_b,
  input  logic [2:0]            cmd_s,
  input  logic                  cmd_cin,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  output logic [2:0]            alu_s,
  input  logic [7:0]            alu_data,
  input  logic                  alu_cout,
  input  logic                  alu_ovf,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_data,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  res_zero
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q,    state_d;
  logic [IDXW-1:0] idx_q,      idx_d;
  logic [W-1:0]    opA_q,      opA_d;
  logic [W-1:0]    opB_q,      opB_d;
  logic [2:0]      sel_q,      sel_d;
  logic            cinSel_q,   cinSel_d;
  logic            carry_q,    carry_d;
  logic [W-1:0]    resData_q,  resData_d;
  logic            resCout_q,  resCout_d;
  logic            resOvf_q,   resOvf_d;
  logic            resZero_q,  resZero_d;
  logic            resValid_q, resValid_d;

  logic [7:0]      sliceA;
  logic [7:0]      sliceB;
  logic [W-1:0]    mergedRes;
  logic            isLogic;

  // Pick out the operand byte for the current index. Shifting by idx*8
  // keeps the select width-clean for any NBYTES, including 1.
  always_comb begin
    sliceA = 8'(opA_q >> {idx_q, 3'b000});
    sliceB = 8'(opB_q >> {idx_q, 3'b000});
  end

  // The result register with the byte at the current index replaced by
  // the live ALU output. On the last byte this is the complete wide result,
  // so the zero flag is taken from it and not from the stale register.
  always_comb begin
    mergedRes = resData_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) begin
        mergedRes[8*i +: 8] = alu_data;
      end
    end
  end

  assign isLogic = sel_q[2];

  // Drive the ALU only while a byte is in flight. Logic ops reuse the
  // latched sub-select on every byte; arithmetic ops use the chained carry.
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    alu_s   = 3'b000;
    if (state_q == EXEC) begin
      alu_a   = sliceA;
      alu_b   = sliceB;
      alu_s   = sel_q;
      alu_cin = isLogic ? cinSel_q : carry_q;
    end
  end

  // Next-state logic for the sequencer. Every register holds by default.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    sel_d      = sel_q;
    cinSel_d   = cinSel_q;
    carry_d    = carry_q;
    resData_d  = resData_q;
    resCout_d  = resCout_q;
    resOvf_d   = resOvf_q;
    resZero_d  = resZero_q;
    resValid_d = resValid_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opA_d    = cmd_a;
          opB_d    = cmd_b;
          sel_d    = cmd_s;
          cinSel_d = cmd_cin;
          carry_d  = cmd_cin;
          idx_d    = '0;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        resData_d = mergedRes;
        carry_d   = alu_cout;
        if (idx_q == LAST_IDX) begin
          // Carry and overflow have no meaning for logic ops.
          resCout_d  = isLogic ? 1'b0 : alu_cout;
          resOvf_d   = isLogic ? 1'b0 : alu_ovf;
          resZero_d  = (mergedRes == '0);
          resValid_d = 1'b1;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        // Result and flags stay put after the handshake; only valid drops.
        if (res_ready) begin
          resValid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset discards any in-flight or pending operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      sel_q      <= '0;
      cinSel_q   <= 1'b0;
      carry_q    <= 1'b0;
      resData_q  <= '0;
      resCout_q  <= 1'b0;
      resOvf_q   <= 1'b0;
      resZero_q  <= 1'b0;
      resValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      sel_q      <= sel_d;
      cinSel_q   <= cinSel_d;
      carry_q    <= carry_d;
      resData_q  <= resData_d;
      resCout_q  <= resCout_d;
      resOvf_q   <= resOvf_d;
      resZero_q  <= resZero_d;
      resValid_q <= resValid_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_cout  = resCout_q;
  assign res_ovf   = resOvf_q;
  assign res_zero  = resZero_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_sequencer
//
// Self-checking bench for alu_wide_sequencer (NBYTES=2). A behavioural 8-bit
// ALU answers the sequencer's byte requests: S=000 adds with carry, S=100 is
// A&B (it deliberately reports cout=ovf=1 so that forcing them to 0 is seen).
// Expected results come from a wide-arithmetic reference model and from a
// hand-computed vector table.
// -----------------------------------------------------------------------------
module tb_alu_wide_sequencer;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic [2:0]     cmd_s;
  logic           cmd_cin;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic           alu_cin;
  logic [2:0]     alu_s;
  logic [7:0]     alu_data;
  logic           alu_cout;
  logic           alu_ovf;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic           res_cout;
  logic           res_ovf;
  logic           res_zero;

  int nCompared   = 0;
  int nMismatched = 0;
  int acceptCount = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } model_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   s;
    logic         cin;
    logic [W-1:0] expRes;
    logic         expCout;
    logic         expOvf;
    logic         expZero;
    logic [1:0]   expCins;
  } vec_t;

  alu_wide_sequencer #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_s     (cmd_s),
    .cmd_cin   (cmd_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_data  (alu_data),
    .alu_cout  (alu_cout),
    .alu_ovf   (alu_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .res_zero  (res_zero)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU sitting downstream of the sequencer.
  always_comb begin
    logic [8:0] sum;
    sum      = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
    alu_data = 8'h00;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_s)
      3'b000: begin
        alu_data = sum[7:0];
        alu_cout = sum[8];
        alu_ovf  = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      3'b100: begin
        alu_data = alu_a & alu_b;
        alu_cout = 1'b1;
        alu_ovf  = 1'b1;
      end
      default: begin
        alu_data = alu_a ^ alu_b;
      end
    endcase
  end

  // Count command handshakes so that over-eager acceptance is visible.
  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) acceptCount++;
  end

  // Watchdog so that the run always ends even if the DUT locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Whole-word reference: add the wide operands directly, or AND them.
  function automatic model_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [2:0] s, input logic c);
    model_t     m;
    logic [W:0] full;
    if (s[2] == 1'b0) begin
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      m.res  = full[W-1:0];
      m.cout = full[W];
      m.ovf  = (a[W-1] == b[W-1]) && (m.res[W-1] != a[W-1]);
    end else begin
      m.res  = a & b;
      m.cout = 1'b0;
      m.ovf  = 1'b0;
    end
    m.zero = (m.res == '0);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Present one command (called at a falling edge), wait for its acceptance,
  // record alu_cin for each byte and stop at the first falling edge where
  // res_valid is seen. latency counts falling edges after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] s, input logic c,
                               output int latency, output logic [1:0] cins,
                               output bit ok);
    int n;
    cmd_a     = a;
    cmd_b     = b;
    cmd_s     = s;
    cmd_cin   = c;
    cmd_valid = 1'b1;
    n         = 0;
    latency   = 0;
    cins      = 2'b00;
    ok        = 1'b0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("acceptTimeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!res_valid && latency < 50) begin
      if (latency < NBYTES) cins[latency] = alu_cin;
      latency++;
      @(negedge clk);
    end
    ok = res_valid;
    if (!ok) checkOutput("resultTimeout", 32'(res_valid), 32'd1);
  endtask

  task automatic consumeResult();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic checkResult(input string tag, input model_t m);
    checkOutput({tag, ".data"}, 32'(res_data), 32'(m.res));
    checkOutput({tag, ".cout"}, 32'(res_cout), 32'(m.cout));
    checkOutput({tag, ".ovf"},  32'(res_ovf),  32'(m.ovf));
    checkOutput({tag, ".zero"}, 32'(res_zero), 32'(m.zero));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".resValid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, ".resData"},  32'(res_data),  32'd0);
    checkOutput({tag, ".resCout"},  32'(res_cout),  32'd0);
    checkOutput({tag, ".resOvf"},   32'(res_ovf),   32'd0);
    checkOutput({tag, ".resZero"},  32'(res_zero),  32'd0);
    checkOutput({tag, ".aluA"},     32'(alu_a),     32'd0);
    checkOutput({tag, ".aluB"},     32'(alu_b),     32'd0);
    checkOutput({tag, ".aluCin"},   32'(alu_cin),   32'd0);
    checkOutput({tag, ".aluS"},     32'(alu_s),     32'd0);
  endtask

  // Main test sequence.
  initial begin
    vec_t         vecs [7];
    model_t       m;
    model_t       expQ [$];
    logic [W-1:0] gotQ [$];
    int           lat;
    logic [1:0]   cins;
    bit           ok;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0]   rs;
    logic         rc;
    int           acceptBase;

    //             a         b         s       cin   expRes    cout  ovf   zero  cins{b1,b0}
    vecs[0] = '{16'h00FF, 16'h0001, 3'b000, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[1] = '{16'h7FFF, 16'h0001, 3'b000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[2] = '{16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b10};
    vecs[3] = '{16'hF0F0, 16'hFF00, 3'b100, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 2'b11};
    vecs[4] = '{16'h1234, 16'h0101, 3'b000, 1'b0, 16'h1335, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[5] = '{16'h8000, 16'h8000, 3'b000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b00};
    vecs[6] = '{16'h0000, 16'h0000, 3'b000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b01};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_s     = '0;
    cmd_cin   = 1'b0;
    res_ready = 1'b0;

    // Reset state.
    #2 rst = 1'b1;
    #1 checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("reset.cmdReady", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Directed vectors from the table.
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].cin, lat, cins, ok);
      if (ok) begin
        checkOutput({tag, ".data"},    32'(res_data), 32'(vecs[i].expRes));
        checkOutput({tag, ".cout"},    32'(res_cout), 32'(vecs[i].expCout));
        checkOutput({tag, ".ovf"},     32'(res_ovf),  32'(vecs[i].expOvf));
        checkOutput({tag, ".zero"},    32'(res_zero), 32'(vecs[i].expZero));
        checkOutput({tag, ".latency"}, 32'(lat),      32'(NBYTES));
        checkOutput({tag, ".aluCin"},  32'(cins),     32'(vecs[i].expCins));
        consumeResult();
        checkOutput({tag, ".validDrop"}, 32'(res_valid), 32'd0);
        checkOutput({tag, ".readyBack"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, ".dataHeld"},  32'(res_data),  32'(vecs[i].expRes));
      end
    end

    // Backpressure: result held while the consumer stalls, stray command ignored.
    applyStimulus(16'h00FF, 16'h0001, 3'b000, 1'b0, lat, cins, ok);
    acceptBase = acceptCount;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        cmd_a     = 16'h5555;
        cmd_b     = 16'h1111;
        cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput($sformatf("stall%0d.valid", k),    32'(res_valid), 32'd1);
      checkOutput($sformatf("stall%0d.data", k),     32'(res_data),  32'h0100);
      checkOutput($sformatf("stall%0d.cmdReady", k), 32'(cmd_ready), 32'd0);
    end
    consumeResult();
    checkOutput("stall.release.cmdReady", 32'(cmd_ready), 32'd1);
    checkOutput("stall.release.valid",    32'(res_valid), 32'd0);
    checkOutput("stall.release.data",     32'(res_data),  32'h0100);
    repeat (3) @(negedge clk);
    checkOutput("stall.noAccept.cmdReady", 32'(cmd_ready), 32'd1);
    checkOutput("stall.noAccept.count",    32'(acceptCount - acceptBase), 32'd0);

    // Reset right after byte 0 has been captured.
    cmd_a     = 16'h1234;
    cmd_b     = 16'h0101;
    cmd_s     = 3'b000;
    cmd_cin   = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("midReset.byte0.aluA", 32'(alu_a), 32'h34);
    @(negedge clk);
    checkOutput("midReset.byte1.aluA", 32'(alu_a), 32'h12);
    rst = 1'b1;
    #1 checkAllZero("midReset");
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("midReset.cmdReady", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("midReset.noValid", 32'(res_valid), 32'd0);
    applyStimulus(16'h1234, 16'h0101, 3'b000, 1'b0, lat, cins, ok);
    if (ok) checkResult("afterReset", refModel(16'h1234, 16'h0101, 3'b000, 1'b0));
    consumeResult();

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000;
      rc = 1'($urandom_range(0, 1));
      m  = refModel(ra, rb, rs, rc);
      applyStimulus(ra, rb, rs, rc, lat, cins, ok);
      if (ok) begin
        checkResult($sformatf("rand%0d", i), m);
        checkOutput($sformatf("rand%0d.latency", i), 32'(lat), 32'(NBYTES));
      end
      consumeResult();
    end

    // Back-to-back: producer keeps cmd_valid high, consumer always ready.
    acceptBase = acceptCount;
    res_ready  = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          ra = W'($urandom);
          rb = W'($urandom);
          rs = (i == 1) ? 3'b100 : 3'b000;
          rc = 1'($urandom_range(0, 1));
          expQ.push_back(refModel(ra, rb, rs, rc));
          cmd_a     = ra;
          cmd_b     = rb;
          cmd_s     = rs;
          cmd_cin   = rc;
          cmd_valid = 1'b1;
          n = 0;
          while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
          end
          @(posedge clk);
          #1;
        end
        cmd_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (gotQ.size() < 3 && n < 200) begin
          @(negedge clk);
          n++;
          if (res_valid) gotQ.push_back(res_data);
        end
      end
    join
    res_ready = 1'b0;
    checkOutput("b2b.count",   32'(gotQ.size()), 32'd3);
    checkOutput("b2b.accepts", 32'(acceptCount - acceptBase), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < gotQ.size()) begin
        checkOutput($sformatf("b2b%0d.data", i), 32'(gotQ[i]), 32'(expQ[i].res));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
